// File: rtl/vga_cfg_pkg.sv
// vga_cfg_pkg: shared FSM state, control-space word offsets and register bit positions
package vga_cfg_pkg;
   typedef enum logic {IDLE, DRAIN} state_t;
   localparam int STATUS_W = 0;
   localparam int CTRL_W = 1;
   localparam int ST_FULL = 8;
   localparam int ST_EMPTY = 9;
   localparam int ST_OVF = 10;
   localparam int ST_COMMIT = 11;
   localparam int ST_VBLANK = 12;
   localparam int ST_DRAIN = 13;
   localparam int CT_IMM = 0;
   localparam int CT_IRQ_EN = 1;
   localparam int CT_CLR_OVF = 2;
   localparam int CT_CLR_COMMIT = 3;
endpackage

// File: rtl/cfg_fifo.sv
// cfg_fifo: synchronous first-word-fall-through FIFO; full is judged on the pre-pop count
module cfg_fifo #(
   parameter int DEPTH = 8,
   parameter int W = 42
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign full = count == CW'(DEPTH);
   assign empty = count == '0;
   assign do_push = push & ~full;
   assign do_pop = pop & ~empty;
   assign dout = mem[rd_ptr];
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
         rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/vblank_cfg_scheduler.sv
// vblank_cfg_scheduler: queues Wishbone graphics-register writes and releases them
// to the core only in vertical blanking (or at once in immediate mode)
module vblank_cfg_scheduler
   import vga_cfg_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int ADDR_W = 6
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_ni,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   input  logic              vblank_i,
   output logic              cfg_valid_o,
   output logic [ADDR_W-1:0] cfg_addr_o,
   output logic [31:0]       cfg_data_o,
   output logic [3:0]        cfg_sel_o,
   input  logic              cfg_ready_i,
   output logic              irq_o
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int W = ADDR_W + 36;
   state_t state, nxt;
   logic req, ctl_space, q_wr, ctrl_wr, push_ok, pop, go, set_commit;
   logic imm, irq_en, ovf, commit, full, empty;
   logic [ADDR_W-1:0] idx;
   logic [CW-1:0] count;
   logic [W-1:0] head;
   logic [31:0] status, rdata;
   logic unused_adr;
   assign unused_adr = &{1'b0, wbs_adr_i[31:ADDR_W+3], wbs_adr_i[1:0]};
   assign req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
   assign ctl_space = wbs_adr_i[ADDR_W+2];
   assign idx = wbs_adr_i[ADDR_W+1:2];
   assign q_wr = req & wbs_we_i & ~ctl_space;
   assign ctrl_wr = req & wbs_we_i & ctl_space & (idx == ADDR_W'(CTRL_W));
   assign push_ok = q_wr & ~full;
   assign go = vblank_i | imm;
   assign cfg_valid_o = (state == DRAIN) & ~empty;
   assign pop = cfg_valid_o & cfg_ready_i;
   // payload is masked while idle so outputs read 0 after reset despite unreset storage
   assign cfg_addr_o = cfg_valid_o ? head[W-1 -: ADDR_W] : '0;
   assign cfg_data_o = cfg_valid_o ? head[35:4] : '0;
   assign cfg_sel_o = cfg_valid_o ? head[3:0] : '0;
   assign irq_o = irq_en & (ovf | commit);
   cfg_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
      .clk(wb_clk_i),
      .rst_n(wb_rst_ni),
      .push(q_wr),
      .pop(pop),
      .din({idx, wbs_dat_i, wbs_sel_i}),
      .dout(head),
      .count(count),
      .full(full),
      .empty(empty)
   );
   always_comb begin
      status = '0;
      status[CW-1:0] = count;
      status[ST_FULL] = full;
      status[ST_EMPTY] = empty;
      status[ST_OVF] = ovf;
      status[ST_COMMIT] = commit;
      status[ST_VBLANK] = vblank_i;
      status[ST_DRAIN] = state == DRAIN;
      rdata = !ctl_space ? '0 :
              idx == ADDR_W'(STATUS_W) ? status :
              idx == ADDR_W'(CTRL_W) ? {30'b0, irq_en, imm} : '0;
   end
   // a pending entry is never withdrawn: leaving on a vblank fall waits for its handshake
   always_comb begin
      set_commit = (state == DRAIN) & pop & (count == CW'(1)) & ~push_ok;
      nxt = state;
      if (state == IDLE)
         nxt = (~empty & go) ? DRAIN : IDLE;
      else
         nxt = (empty | set_commit | (~go & pop)) ? IDLE : DRAIN;
   end
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         state <= IDLE;
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         imm <= 1'b0;
         irq_en <= 1'b0;
         ovf <= 1'b0;
         commit <= 1'b0;
      end else begin
         state <= nxt;
         wbs_ack_o <= req;
         wbs_dat_o <= (req & ~wbs_we_i) ? rdata : '0;
         imm <= ctrl_wr ? wbs_dat_i[CT_IMM] : imm;
         irq_en <= ctrl_wr ? wbs_dat_i[CT_IRQ_EN] : irq_en;
         ovf <= (q_wr & full) | (ovf & ~(ctrl_wr & wbs_dat_i[CT_CLR_OVF]));
         commit <= set_commit | (commit & ~(ctrl_wr & wbs_dat_i[CT_CLR_COMMIT]));
      end
   end
endmodule

// File: tb/tb_vblank_cfg_scheduler.sv
// tb_vblank_cfg_scheduler: directed vectors with hand-computed expectations
module tb_vblank_cfg_scheduler;
   logic clk = 0, rst_n = 0, cyc = 0, stb = 0, we = 0, vblank = 0, ready = 0;
   logic [3:0] sel = 0;
   logic [31:0] adr = 0, wdat = 0;
   logic ack, valid, irq;
   logic [31:0] rdat, cdata;
   logic [5:0] caddr;
   logic [3:0] csel;
   logic [31:0] r;
   int total = 0, bad = 0;
   localparam logic [31:0] STATUS_A = 32'h100, CTRL_A = 32'h104;

   vblank_cfg_scheduler #(.DEPTH(8), .ADDR_W(6)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb),
      .wbs_we_i(we), .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat),
      .wbs_ack_o(ack), .wbs_dat_o(rdat), .vblank_i(vblank), .cfg_valid_o(valid),
      .cfg_addr_o(caddr), .cfg_data_o(cdata), .cfg_sel_o(csel),
      .cfg_ready_i(ready), .irq_o(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] q);
      @(negedge clk);
      cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
      @(negedge clk);
      chk("ack", {31'b0, ack}, 1);
      q = rdat;
      cyc = 0; stb = 0; we = 0;
   endtask

   task automatic expect_out(input string tag, input logic [5:0] a, input logic [31:0] d,
                             input logic [3:0] s);
      chk({tag, "_valid"}, {31'b0, valid}, 1);
      chk({tag, "_addr"}, {26'b0, caddr}, {26'b0, a});
      chk({tag, "_data"}, cdata, d);
      chk({tag, "_sel"}, {28'b0, csel}, {28'b0, s});
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_ack", {31'b0, ack}, 0);
      chk("rst_dat", rdat, 0);
      chk("rst_valid", {31'b0, valid}, 0);
      chk("rst_payload", {caddr, cdata[25:0]} | {26'b0, csel}, 0);
      chk("rst_irq", {31'b0, irq}, 0);
      rst_n = 1;
      // three queued writes while vblank is low stay held
      wb(1, 32'h4, 32'hAAAA_0001, 4'hF, r);
      wb(1, 32'h8, 32'hBBBB_0002, 4'h3, r);
      wb(1, 32'hC, 32'hCCCC_0003, 4'h0, r);
      wb(0, STATUS_A, 0, 4'hF, r);
      chk("status_cnt3", r, 32'h3);
      chk("hold_novalid", {31'b0, valid}, 0);
      wb(0, 32'h4, 0, 4'hF, r);
      chk("qread_zero", r, 0);
      wb(1, CTRL_A, 32'h2, 4'hF, r);
      wb(0, CTRL_A, 0, 4'hF, r);
      chk("ctrl_rd", r, 32'h2);
      @(negedge clk);
      vblank = 1; ready = 1;
      @(negedge clk); expect_out("a", 6'd1, 32'hAAAA_0001, 4'hF);
      @(negedge clk); expect_out("b", 6'd2, 32'hBBBB_0002, 4'h3);
      @(negedge clk); expect_out("c", 6'd3, 32'hCCCC_0003, 4'h0);
      @(negedge clk);
      chk("drained_valid", {31'b0, valid}, 0);
      chk("commit_irq", {31'b0, irq}, 1);
      wb(0, STATUS_A, 0, 4'hF, r);
      chk("status_commit", r, 32'h1A00);
      wb(1, CTRL_A, 32'hA, 4'hF, r);
      chk("irq_cleared", {31'b0, irq}, 0);
      wb(0, CTRL_A, 0, 4'hF, r);
      chk("ctrl_wo_bits", r, 32'h2);
      vblank = 0; ready = 0;
      // nine writes into an eight-deep queue
      for (int i = 0; i < 9; i++) wb(1, 32'(i) << 2, 32'h9000_0000 + 32'(i), 4'hF, r);
      wb(0, STATUS_A, 0, 4'hF, r);
      chk("status_ovf", r, 32'h508);
      chk("ovf_irq", {31'b0, irq}, 1);
      // vblank falls while the head waits on ready
      @(negedge clk); vblank = 1;
      @(negedge clk); expect_out("hold0", 6'd0, 32'h9000_0000, 4'hF);
      vblank = 0;
      @(negedge clk); expect_out("hold1", 6'd0, 32'h9000_0000, 4'hF);
      ready = 1;
      @(negedge clk); ready = 0;
      chk("fall_valid", {31'b0, valid}, 0);
      wb(0, STATUS_A, 0, 4'hF, r);
      chk("status_after_fall", r, 32'h407);
      @(negedge clk); vblank = 1; ready = 1;
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         expect_out($sformatf("rest%0d", i), 6'(i), 32'h9000_0000 + 32'(i), 4'hF);
      end
      @(negedge clk);
      chk("ninth_absent", {31'b0, valid}, 0);
      vblank = 0; ready = 0;
      wb(1, CTRL_A, 32'hC, 4'hF, r);
      wb(0, STATUS_A, 0, 4'hF, r);
      chk("status_clr", r, 32'h200);
      // immediate mode ignores vblank
      wb(1, CTRL_A, 32'h1, 4'hF, r);
      wb(1, 32'h14, 32'hDDDD_0005, 4'h5, r);
      chk("imm_early", {31'b0, valid}, 0);
      @(negedge clk); expect_out("imm", 6'd5, 32'hDDDD_0005, 4'h5);
      for (int i = 0; i < 3; i++) wb(1, 32'h20 + (32'(i) << 2), 32'hEEEE_0000 + 32'(i), 4'hF, r);
      wb(0, STATUS_A, 0, 4'hF, r);
      chk("status_drain4", r, 32'h2004);
      // reset in the middle of a drain
      @(negedge clk); rst_n = 0;
      @(negedge clk);
      chk("rst_mid_valid", {31'b0, valid}, 0);
      rst_n = 1;
      wb(0, STATUS_A, 0, 4'hF, r);
      chk("rst_status", r, 32'h200);
      wb(0, CTRL_A, 0, 4'hF, r);
      chk("rst_ctrl", r, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
